superscalar_fetch: RTL and testbench

Parametrised instruction-fetch front end for the superscalar pipeline, replacing the single-issue ins_fetch.
- Holds the PC and issues FETCH_WIDTH-wide requests to a 1-cycle synchronous instruction memory.
- Buffers returned bundles in a flushable queue and hands them to decode over a valid/ready handshake.
- load_pc redirects the PC (branch/jump/exception), flushing queued and in-flight bundles.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_queue.sv | 49 ++++
 rtl/superscalar_fetch.sv | 95 +++++++++
 tb/tb_superscalar_fetch.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the superscalar instruction-fetch front end.
package fetch_pkg;
    localparam int INSTR_W = 32;
    localparam int BYTES_PER_INSTR = 4;
    localparam logic [31:0] DEFAULT_PC_START = 32'h0040_0020;

    typedef logic [31:0] addr_t;

    // Address of the bundle following the one at pc; wraps modulo 2^32.
    function automatic addr_t next_bundle_pc(input addr_t pc, input int fetch_width);
        return pc + addr_t'(BYTES_PER_INSTR * fetch_width);
    endfunction
endpackage

// File: rtl/fetch_queue.sv
// Flushable FIFO for fetched bundles; head shows the oldest entry.
module fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;

    assign pop_ok = pop && (count != '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop_ok);
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/superscalar_fetch.sv
// Fetch front end: PC, one-deep request tracking with queue-slot reservation,
// and a bundle queue handed to decode over valid/ready.
module superscalar_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_START    = DEFAULT_PC_START,
    parameter int          FETCH_WIDTH = 2,
    parameter int          BUF_DEPTH   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load_pc,
    input  logic [31:0]                    pc_in,
    output logic                           imem_req,
    output logic [31:0]                    imem_addr,
    input  logic [INSTR_W*FETCH_WIDTH-1:0] imem_rdata,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    out_pc,
    output logic [INSTR_W*FETCH_WIDTH-1:0] out_instr
);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    typedef struct packed {
        addr_t                           pc;
        logic [INSTR_W*FETCH_WIDTH-1:0]  instr;
    } bundle_t;

    localparam int BUNDLE_W = $bits(bundle_t);

    addr_t               pc;
    addr_t               req_pc;
    logic                inflight;
    logic [CNT_W-1:0]    count;
    logic [CNT_W:0]      reserved;
    logic [BUNDLE_W-1:0] head_raw;
    bundle_t             head;
    bundle_t             last_popped;
    bundle_t             shown;
    bundle_t             resp;
    logic                push;
    logic                pop;

    // An in-flight request already owns a queue slot, so its response can never overflow.
    assign reserved  = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign imem_req  = !reset && !load_pc && (reserved < (CNT_W+1)'(BUF_DEPTH));
    assign imem_addr = pc;

    assign out_valid = (count != '0);
    assign push      = inflight && !load_pc;
    assign pop       = out_valid && out_ready && !load_pc;

    assign resp.pc    = req_pc;
    assign resp.instr = imem_rdata;
    assign head       = bundle_t'(head_raw);
    assign shown      = out_valid ? head : last_popped;
    assign out_pc     = shown.pc;
    assign out_instr  = shown.instr;

    fetch_queue #(
        .WIDTH (BUNDLE_W),
        .DEPTH (BUF_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (reset),
        .flush     (load_pc),
        .push      (push),
        .push_data (resp),
        .pop       (pop),
        .head      (head_raw),
        .count     (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= PC_START;
            req_pc      <= '0;
            inflight    <= 1'b0;
            last_popped <= '0;
        end else begin
            if (out_valid && out_ready)
                last_popped <= head;
            if (load_pc) begin
                pc       <= pc_in;
                inflight <= 1'b0;
            end else begin
                inflight <= imem_req;
                if (imem_req) begin
                    pc     <= next_bundle_pc(pc, FETCH_WIDTH);
                    req_pc <= pc;
                end
            end
        end
    end
endmodule

// File: tb/tb_superscalar_fetch.sv
// Directed bench for superscalar_fetch with a synchronous imem model and a bundle scoreboard.
module tb_superscalar_fetch;
    localparam logic [31:0] PC_START = 32'h0040_0020;

    logic        clk;
    logic        reset;
    logic        load_pc;
    logic [31:0] pc_in;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [63:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [63:0] out_instr;

    int checks;
    int errors;

    logic [31:0] exp_pc;
    logic [31:0] infl_pc;
    bit          infl;
    logic [31:0] sb [$];

    superscalar_fetch #(
        .PC_START    (PC_START),
        .FETCH_WIDTH (2),
        .BUF_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_pc    (load_pc),
        .pc_in      (pc_in),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_instr  (out_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [63:0] bundle_data(input logic [31:0] a);
        return {word(a + 32'd4), word(a)};
    endfunction

    initial imem_rdata = '0;
    always @(posedge clk) begin
        if (imem_req)
            imem_rdata <= bundle_data(imem_addr);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(1'b0));
        chk({tag, "_imem_req"},  64'(imem_req),  64'(1'b0));
        chk({tag, "_out_pc"},    64'(out_pc),    64'(32'h0));
        chk({tag, "_out_instr"}, out_instr,      64'h0);
        chk({tag, "_imem_addr"}, 64'(imem_addr), 64'(PC_START));
    endtask

    task automatic model_reset();
        sb.delete();
        infl   = 1'b0;
        exp_pc = PC_START;
    endtask

    // Called at negedge+1: drive, check, advance the model across the next posedge.
    task automatic step(input logic ld, input logic [31:0] pin, input logic rdy);
        bit exp_req;
        bit fire;
        load_pc   = ld;
        pc_in     = pin;
        out_ready = rdy;
        #1;
        exp_req = !ld && ((sb.size() + int'(infl)) < 4);
        chk("imem_req",  64'(imem_req),  64'(exp_req));
        chk("imem_addr", 64'(imem_addr), 64'(exp_pc));
        chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("out_pc",    64'(out_pc), 64'(sb[0]));
            chk("out_instr", out_instr,   bundle_data(sb[0]));
        end
        fire = (sb.size() != 0) && rdy;
        if (ld) begin
            sb.delete();
            infl   = 1'b0;
            exp_pc = pin;
        end else begin
            if (fire)
                void'(sb.pop_front());
            if (infl)
                sb.push_back(infl_pc);
            infl = exp_req;
            if (exp_req) begin
                infl_pc = exp_pc;
                exp_pc  = exp_pc + 32'd8;
            end
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        load_pc   = 1'b0;
        pc_in     = '0;
        out_ready = 1'b1;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_reset("por");
        reset = 1'b0;

        // streaming with decode always ready
        repeat (8) step(1'b0, 32'h0, 1'b1);

        // asynchronous reset mid-cycle while streaming
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_reset("async");
        @(negedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        // decode stalled: queue fills, then drains in order
        repeat (7) step(1'b0, 32'h0, 1'b0);
        repeat (8) step(1'b0, 32'h0, 1'b1);

        // redirect with three bundles queued and one in flight
        step(1'b1, 32'h0040_0200, 1'b0);
        repeat (4) step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0040_0100, 1'b0);
        repeat (6) step(1'b0, 32'h0, 1'b1);

        // decode ready toggling every cycle
        for (int i = 0; i < 12; i++)
            step(1'b0, 32'h0, (i % 2) == 0);
        repeat (4) step(1'b0, 32'h0, 1'b1);

        // pc wraps past the top of the address space
        step(1'b1, 32'hFFFF_FFF8, 1'b1);
        repeat (5) step(1'b0, 32'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
